rr_grant_scheduler: RTL and testbench

- Sequential round-robin scheduler that shares one 16-way resource between 16 requesters.
- Each cycle it can pick a winner from a 16-bit request vector using a rotating-priority encoder, then holds that grant until the requester releases it or a hold timeout expires.
- Sits in front of the shared datapath. It drives the one-hot select and a binary index, taking over the static job a fixed-priority encoder does for a bus-select stage.

---
 rtl/rr_sched_pkg.sv | 26 ++
 rtl/rr_grant_scheduler_if.sv | 31 +++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_grant_scheduler.sv | 91 +++++++++
 tb/tb_rr_grant_scheduler.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler.
// Contents:
//   N_REQ, IDW     - default requester count and matching index width
//   state_t        - scheduler FSM states
//   onehot_to_bin  - one-hot to binary index encoder
package rr_sched_pkg;

  localparam int N_REQ = 16;
  localparam int IDW   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // OR-reduction encoder: exact for one-hot input, returns 0 for all-zero.
  function automatic logic [IDW-1:0] onehot_to_bin(input logic [N_REQ-1:0] oh);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between a requester group and the scheduler.
// Signals:
//   enable      - scheduler enable
//   req         - request vector, one bit per requester
//   grant       - one-hot grant
//   grant_id    - binary index of the grant
//   grant_valid - a grant is active
//   timeout     - one-cycle pulse when a grant is revoked by the hold limit
interface rr_grant_scheduler_if #(
  parameter int N   = 16,
  parameter int IDW = 4
);

  logic           enable;
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           timeout;

  modport master (
    output enable, req,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  enable, req,
    output grant, grant_id, grant_valid, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   req      - request vector
//   last_ptr - index of the previous winner; search begins just above it
//   any      - at least one request is set
//   winner   - first set request at or after last_ptr+1, wrapping upward
module rr_pick #(
  parameter int N   = 16,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_ptr,
  output logic           any,
  output logic [IDW-1:0] winner
);

  logic [IDW-1:0] start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;

  // N is a power of two, so IDW-bit arithmetic wraps mod N for free.
  always_comb begin
    start = last_ptr + IDW'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
    any   = |req;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    winner = off + start;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: grants one of N requesters and holds the grant
// until release, disable or the MAX_HOLD limit.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - request/grant bundle (slave side)
//
// state | meaning
// IDLE  | no grant; arbitrate among req when enabled
// GRANT | grant held for grant_id; hold_cnt counts cycles already held
import rr_sched_pkg::*;

module rr_grant_scheduler #(
  parameter int N        = N_REQ,
  parameter int IDW      = rr_sched_pkg::IDW,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic reset,
  rr_grant_scheduler_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t         state;
  logic [7:0]     hold_cnt;
  logic [IDW-1:0] last_ptr;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic           valid_q;
  logic           timeout_q;
  logic           pick_any;
  logic [IDW-1:0] pick_winner;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .winner   (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_ptr   <= IDW'(N - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && pick_any) begin
            state      <= GRANT;
            grant_q    <= N'(1) << pick_winner;
            grant_id_q <= pick_winner;
            valid_q    <= 1'b1;
            hold_cnt   <= '0;
            last_ptr   <= pick_winner;
          end
        end
        GRANT: begin
          // Release is checked before the hold limit so it suppresses timeout.
          if (!bus.enable || !bus.req[grant_id_q]) begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            valid_q    <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench: two schedulers (MAX_HOLD 8 and 4) share one stimulus
// stream and are each compared every cycle against a behavioural model.
import rr_sched_pkg::*;

module tb_rr_grant_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rr_grant_scheduler_if #(.N(16), .IDW(4)) bus_a ();
  rr_grant_scheduler_if #(.N(16), .IDW(4)) bus_b ();

  rr_grant_scheduler #(.N(16), .IDW(4), .MAX_HOLD(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  rr_grant_scheduler #(.N(16), .IDW(4), .MAX_HOLD(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: current grant id (-1 none), cycles it has been visible, last winner.
  int m_gid [2];
  int m_cnt [2];
  int m_last[2];
  bit m_to  [2];
  int m_max [2] = '{8, 4};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input int k, input bit rst, input bit en, input logic [15:0] rq);
    bit found;
    if (rst) begin
      m_gid[k] = -1; m_cnt[k] = 0; m_last[k] = 15; m_to[k] = 0;
    end else if (m_gid[k] < 0) begin
      m_to[k] = 0;
      if (en && rq != 16'h0) begin
        found = 0;
        for (int i = 1; i <= 16; i++) begin
          if (!found && rq[(m_last[k] + i) % 16]) begin
            found = 1;
            m_gid[k] = (m_last[k] + i) % 16;
          end
        end
        m_last[k] = m_gid[k];
        m_cnt[k] = 1;
      end
    end else begin
      m_to[k] = 0;
      if (!en || !rq[m_gid[k]]) begin
        m_gid[k] = -1;
      end else if (m_cnt[k] == m_max[k]) begin
        m_gid[k] = -1;
        m_to[k] = 1;
      end else begin
        m_cnt[k]++;
      end
    end
  endfunction

  task automatic compare_all();
    logic [15:0] g;
    logic [3:0]  gi;
    logic        gv, to;
    logic [15:0] eg;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin g = bus_a.grant; gi = bus_a.grant_id; gv = bus_a.grant_valid; to = bus_a.timeout; end
      else        begin g = bus_b.grant; gi = bus_b.grant_id; gv = bus_b.grant_valid; to = bus_b.timeout; end
      eg = (m_gid[k] >= 0) ? (16'h1 << m_gid[k]) : 16'h0;
      check_eq(k == 0 ? "a.grant" : "b.grant", 32'(g), 32'(eg));
      check_eq(k == 0 ? "a.grant_valid" : "b.grant_valid", 32'(gv), 32'(m_gid[k] >= 0));
      check_eq(k == 0 ? "a.timeout" : "b.timeout", 32'(to), 32'(m_to[k]));
      if (m_gid[k] >= 0)
        check_eq(k == 0 ? "a.grant_id" : "b.grant_id", 32'(gi), 32'(m_gid[k]));
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [15:0] rq);
    reset = rst;
    bus_a.enable = en; bus_a.req = rq;
    bus_b.enable = en; bus_b.req = rq;
    @(posedge clk);
    model_step(0, rst, en, rq);
    model_step(1, rst, en, rq);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0]  seq[$];
    logic        prev_v;
    logic [15:0] rq, prev_rq;
    int          vcnt;
    bit          en, rst;

    bus_a.enable = 0; bus_a.req = '0;
    bus_b.enable = 0; bus_b.req = '0;

    // Reset state
    step(1, 0, 16'h0);
    step(1, 1, 16'hFFFF);

    // Single requester held three edges
    step(0, 1, 16'h0010);
    check_eq("single.id", 32'(bus_a.grant_id), 32'd4);
    step(0, 1, 16'h0010);
    step(0, 1, 16'h0010);
    step(0, 1, 16'h0000);
    check_eq("single.drop", 32'(bus_a.grant_valid), 32'd0);

    // Rotation with release after two visible cycles
    step(1, 0, 16'h0);
    seq.delete(); prev_v = 0;
    for (int c = 0; c < 120 && seq.size() < 17; c++) begin
      rq = 16'hFFFF;
      if (m_gid[0] >= 0 && m_cnt[0] == 2) rq[m_gid[0]] = 1'b0;
      step(0, 1, rq);
      if (bus_a.grant_valid && !prev_v) seq.push_back(onehot_to_bin(bus_a.grant));
      prev_v = bus_a.grant_valid;
    end
    check_eq("rot.count", 32'(seq.size()), 32'd17);
    for (int i = 0; i < seq.size(); i++) check_eq("rot.seq", 32'(seq[i]), 32'(i % 16));

    // Timeout on instance A (MAX_HOLD=8): 8 visible cycles then a timeout bubble
    step(1, 0, 16'h0);
    vcnt = 0;
    for (int j = 0; j < 9; j++) begin
      step(0, 1, 16'h0008);
      if (bus_a.grant_valid) vcnt++;
    end
    check_eq("to.len", 32'(vcnt), 32'd8);
    check_eq("to.pulse", 32'(bus_a.timeout), 32'd1);
    step(0, 1, 16'h0008);
    check_eq("to.regrant", 32'(bus_a.grant_id), 32'd3);

    // Fairness after timeout on instance B (MAX_HOLD=4)
    step(1, 0, 16'h0);
    seq.delete(); prev_v = 0;
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      step(0, 1, 16'h0009);
      if (bus_b.grant_valid && !prev_v) seq.push_back(onehot_to_bin(bus_b.grant));
      prev_v = bus_b.grant_valid;
    end
    check_eq("fair.count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++) check_eq("fair.seq", 32'(seq[i]), (i % 2 == 0) ? 32'd0 : 32'd3);

    // Enable abort and reset mid-grant
    step(1, 0, 16'h0);
    step(0, 1, 16'h0080);
    check_eq("abort.id", 32'(bus_a.grant_id), 32'd7);
    step(0, 1, 16'h0080);
    step(0, 0, 16'h0080);
    for (int j = 0; j < 3; j++) step(0, 0, 16'h0080);
    check_eq("abort.idle", 32'(bus_a.grant_valid), 32'd0);
    step(0, 1, 16'h0080);
    step(1, 1, 16'h0080);
    step(0, 1, 16'hFFFF);
    check_eq("abort.restart", 32'(bus_a.grant_id), 32'd0);

    // Wrap priority from last_ptr=14
    step(1, 0, 16'h0);
    step(0, 1, 16'h4000);
    step(0, 1, 16'h0000);
    step(0, 1, 16'h8002);
    check_eq("wrap.first", 32'(bus_a.grant_id), 32'd15);
    step(0, 1, 16'h0002);
    step(0, 1, 16'h0002);
    check_eq("wrap.second", 32'(bus_a.grant_id), 32'd1);

    // Randomized traffic
    prev_rq = 16'h0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 7) rq = prev_rq;
      else if ($urandom_range(0, 3) == 0) rq = 16'h0;
      else begin
        rq = 16'($urandom);
        if ($urandom_range(0, 1) == 1) rq = rq & 16'($urandom) & 16'($urandom);
      end
      prev_rq = rq;
      step(rst, en, rq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
